// File: rtl/jtframe_osd_pkg.sv
// Shared types and constants for the OSD status receiver: FSM encoding,
// default command bytes and datapath widths.
package jtframe_osd_pkg;

  localparam int STATUS_W = 32;
  localparam int CNT_W    = 3;

  localparam logic [7:0] CMD_ST32_DEF = 8'h1E;
  localparam logic [7:0] CMD_ST8_DEF  = 8'h15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_SKIP = 2'd3
  } rx_state_e;

  // Number of payload bytes a well-formed frame must carry.
  function automatic logic [CNT_W-1:0] exp_count(input logic is32);
    if (is32) begin
      return 3'd4;
    end else begin
      return 3'd1;
    end
  endfunction

endpackage

// File: rtl/jtframe_status_pulse.sv
// Self-clearing status bits: after each commit, bits in PULSE_MASK stay
// visible for PULSE_LEN cycles and are then cleared.
module jtframe_status_pulse
  import jtframe_osd_pkg::*;
#(
  parameter logic [STATUS_W-1:0] INIT       = 32'h0,
  parameter logic [STATUS_W-1:0] PULSE_MASK = 32'h1,
  parameter int                  PULSE_LEN  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                commit,
  input  logic [STATUS_W-1:0] value,
  output logic [STATUS_W-1:0] status
);

  localparam logic [15:0] LEN16 = 16'(PULSE_LEN);

  logic [15:0]         cnt_q, cnt_d;
  logic [STATUS_W-1:0] out_q, out_d;

  // Reload on commit; mask is applied on the 1 -> 0 counter transition.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (commit) begin
      cnt_d = LEN16;
      out_d = value;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
      if (cnt_q == 16'd1) begin
        out_d = out_q & ~PULSE_MASK;
      end else begin
        out_d = out_q;
      end
    end else begin
      cnt_d = 16'd0;
    end
  end

  // Counter and displayed status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
      out_q <= INIT;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign status = out_q;

endmodule

// File: rtl/jtframe_status_rx.sv
// Assembles the 32-bit OSD status word from controller command frames and
// commits it atomically on frame end. Optional self-clear: JTFRAME_STATUS_PULSE_EN.
module jtframe_status_rx
  import jtframe_osd_pkg::*;
#(
  parameter logic [STATUS_W-1:0] INIT     = 32'h0,
  parameter logic [7:0]          CMD_ST32 = CMD_ST32_DEF,
  parameter logic [7:0]          CMD_ST8  = CMD_ST8_DEF
`ifdef JTFRAME_STATUS_PULSE_EN
  , parameter logic [STATUS_W-1:0] PULSE_MASK = 32'h1,
  parameter int                  PULSE_LEN  = 16
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic                frame_end,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic [STATUS_W-1:0] status,
  output logic                status_upd,
  output logic                busy,
  output logic                err
);

  rx_state_e           state_q, state_d, cmd_state_s;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is32_q, is32_d, cmd_is32_s;
  logic [STATUS_W-1:0] shadow_q, shadow_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic                upd_q, upd_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                commit_s;

  // Command byte decode, shared by the frame_start+byte and CMD-state paths.
  always_comb begin
    cmd_is32_s = (byte_in == CMD_ST32);
    if (byte_in == CMD_ST32 || byte_in == CMD_ST8) begin
      cmd_state_s = ST_DATA;
    end else begin
      cmd_state_s = ST_SKIP;
    end
  end

  // Frame FSM: byte handling happens before the frame_end commit check.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is32_d   = is32_q;
    shadow_d = shadow_q;
    status_d = status_q;
    busy_d   = busy_q;
    err_d    = err_q;
    commit_s = 1'b0;
    if (frame_start) begin
      err_d    = err_q | busy_q;
      busy_d   = 1'b1;
      shadow_d = '0;
      cnt_d    = '0;
      if (byte_valid) begin
        state_d = cmd_state_s;
        is32_d  = cmd_is32_s;
      end else begin
        state_d = ST_CMD;
      end
    end else if (state_q != ST_IDLE) begin
      if (byte_valid) begin
        case (state_q)
          ST_CMD: begin
            state_d = cmd_state_s;
            is32_d  = cmd_is32_s;
          end
          ST_DATA: begin
            if (cnt_q < exp_count(is32_q)) begin
              shadow_d[{cnt_q[1:0], 3'b000} +: 8] = byte_in;
              cnt_d = cnt_q + 3'd1;
            end else begin
              cnt_d = cnt_q;
            end
          end
          default: state_d = state_q;
        endcase
      end else begin
        state_d = state_q;
      end
      if (frame_end) begin
        if (state_d == ST_DATA) begin
          if (cnt_d == exp_count(is32_d)) begin
            commit_s = 1'b1;
            status_d = is32_d ? shadow_d : {status_q[STATUS_W-1:8], shadow_d[7:0]};
          end else begin
            err_d = 1'b1;
          end
        end else begin
          err_d = err_q;
        end
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end else begin
        busy_d = busy_q;
      end
    end else begin
      state_d = ST_IDLE;
    end
    upd_d = commit_s;
  end

  // State, shadow and committed-status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is32_q   <= 1'b0;
      shadow_q <= '0;
      status_q <= INIT;
      upd_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is32_q   <= is32_d;
      shadow_q <= shadow_d;
      status_q <= status_d;
      upd_q    <= upd_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

`ifdef JTFRAME_STATUS_PULSE_EN
  jtframe_status_pulse #(
    .INIT       (INIT),
    .PULSE_MASK (PULSE_MASK),
    .PULSE_LEN  (PULSE_LEN)
  ) u_pulse (
    .clk    (clk),
    .rst_n  (rst_n),
    .commit (commit_s),
    .value  (status_d),
    .status (status)
  );
`else
  assign status = status_q;
`endif

  assign status_upd = upd_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_jtframe_status_rx.sv
// Self-checking bench for jtframe_status_rx: directed frames plus randomized
// frames compared against a frame-level reference model.
module tb_jtframe_status_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic [31:0] status;
  logic        status_upd;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] m_status;
  bit          m_err;
  bit          have_commit;
  int          commit_cyc;

  localparam logic [31:0] INIT_V = 32'h0;

  jtframe_status_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .status      (status),
    .status_upd  (status_upd),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Frame-level model: decides the outcome from the whole byte list.
  function automatic void model_frame(input logic [7:0] fb[$], output bit commit);
    commit = 1'b0;
    if (fb.size() == 0) return;
    if (fb[0] == 8'h1E) begin
      if (fb.size() >= 5) begin
        m_status = {fb[4], fb[3], fb[2], fb[1]};
        commit = 1'b1;
      end else m_err = 1'b1;
    end else if (fb[0] == 8'h15) begin
      if (fb.size() >= 2) begin
        m_status[7:0] = fb[1];
        commit = 1'b1;
      end else m_err = 1'b1;
    end
  endfunction

  function automatic logic [31:0] shown_status();
`ifdef JTFRAME_STATUS_PULSE_EN
    if (have_commit && (cyc - commit_cyc) >= 16) return m_status & ~32'h1;
`endif
    return m_status;
  endfunction

  task automatic do_reset;
    rst_n = 1'b0;
    frame_start = 1'b0; frame_end = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    tick; tick;
    rst_n = 1'b1;
    tick;
    m_status = INIT_V; m_err = 1'b0; have_commit = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    byte_in = b; byte_valid = 1'b1;
    tick;
    byte_valid = 1'b0;
  endtask

  // Drives one frame; returns after the frame_end edge with the model updated.
  task automatic send_frame(input logic [7:0] fb[$], input bit first_w_start,
                            input bit last_w_end, input bit gaps, output bit commit);
    int  n = fb.size();
    int  i = 0;
    bit  ended = 1'b0;
    frame_start = 1'b1;
    if (first_w_start && n > 0) begin
      byte_in = fb[0]; byte_valid = 1'b1; i = 1;
    end
    tick;
    frame_start = 1'b0; byte_valid = 1'b0;
    while (i < n) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick;
      byte_in = fb[i]; byte_valid = 1'b1;
      if (i == n - 1 && last_w_end) begin
        frame_end = 1'b1; ended = 1'b1;
      end
      tick;
      byte_valid = 1'b0; frame_end = 1'b0;
      i++;
    end
    if (!ended) begin
      frame_end = 1'b1;
      tick;
      frame_end = 1'b0;
    end
    model_frame(fb, commit);
    if (commit) begin
      have_commit = 1'b1;
      commit_cyc = cyc;
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if (status !== INIT_V || status_upd !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset status=%h upd=%b busy=%b err=%b want %h 0 0 0",
               status, status_upd, busy, err, INIT_V);
    end
  endtask

  task automatic test_empty_frame;
    frame_start = 1'b1; tick; frame_start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_open got %b want 1", busy); end
    frame_end = 1'b1; tick; frame_end = 1'b0;
    checks++;
    if (busy !== 1'b0 || status_upd !== 1'b0 || err !== 1'b0 || status !== shown_status()) begin
      errors++;
      $display("FAIL empty_frame busy=%b upd=%b err=%b status=%h want 0 0 0 %h",
               busy, status_upd, err, status, shown_status());
    end
  endtask

  task automatic test_st32;
    logic [7:0] q[$];
    bit c;
    q = {8'h1E, 8'h78, 8'h56, 8'h34, 8'h12};
    send_frame(q, 1'b0, 1'b0, 1'b0, c);
    checks++;
    if (status !== 32'h12345678 || status_upd !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL st32 status=%h upd=%b busy=%b err=%b want 12345678 1 0 0",
               status, status_upd, busy, err);
    end
    tick;
    checks++;
    if (status_upd !== 1'b0) begin errors++; $display("FAIL st32_upd_width got %b want 0", status_upd); end
  endtask

  task automatic test_st8;
    logic [7:0] q[$];
    bit c;
    q = {8'h15, 8'hAB};
    send_frame(q, 1'b0, 1'b0, 1'b0, c);
    checks++;
    if (status !== 32'h123456AB || status_upd !== 1'b1) begin
      errors++;
      $display("FAIL st8 status=%h upd=%b want 123456ab 1", status, status_upd);
    end
  endtask

  task automatic test_skip_and_oversize;
    logic [7:0] q[$];
    bit c;
    q = {8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(q, 1'b0, 1'b0, 1'b0, c);
    checks++;
    if (status !== shown_status() || status_upd !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL skip status=%h upd=%b err=%b want %h 0 0", status, status_upd, err, shown_status());
    end
    q = {8'h1E, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    send_frame(q, 1'b0, 1'b0, 1'b1, c);
    checks++;
    if (status !== 32'hD4C3B2A1 || status_upd !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL oversize status=%h upd=%b err=%b want d4c3b2a1 1 0", status, status_upd, err);
    end
  endtask

  task automatic test_short;
    logic [7:0] q[$];
    bit c;
    q = {8'h1E, 8'h11, 8'h22};
    send_frame(q, 1'b0, 1'b0, 1'b0, c);
    checks++;
    if (status !== shown_status() || status_upd !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL short status=%h upd=%b err=%b want %h 0 1", status, status_upd, err, shown_status());
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] q[$];
    bit c;
    frame_start = 1'b1; tick; frame_start = 1'b0;
    drive_byte(8'h1E);
    drive_byte(8'h01);
    rst_n = 1'b0;
    #2;
    checks++;
    if (status !== INIT_V || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset status=%h busy=%b err=%b want %h 0 0", status, busy, err, INIT_V);
    end
    tick;
    rst_n = 1'b1;
    tick;
    m_status = INIT_V; m_err = 1'b0; have_commit = 1'b0;
    q = {8'h1E, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
    send_frame(q, 1'b0, 1'b0, 1'b0, c);
    checks++;
    if (status !== 32'h0A0B0C0D || status_upd !== 1'b1) begin
      errors++;
      $display("FAIL after_reset status=%h upd=%b want 0a0b0c0d 1", status, status_upd);
    end
  endtask

  task automatic test_abort;
    logic [7:0] q[$];
    bit c;
    frame_start = 1'b1; tick; frame_start = 1'b0;
    drive_byte(8'h1E);
    drive_byte(8'h01);
    drive_byte(8'h02);
    m_err = 1'b1;
    q = {8'h1E, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(q, 1'b0, 1'b0, 1'b0, c);
    checks++;
    if (status !== 32'hDDCCBBAA || status_upd !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL abort status=%h upd=%b err=%b want ddccbbaa 1 1", status, status_upd, err);
    end
  endtask

  task automatic test_same_cycle;
    logic [7:0] q[$];
    bit c;
    q = {8'h1E, 8'h44, 8'h33, 8'h22, 8'h11};
    send_frame(q, 1'b1, 1'b1, 1'b0, c);
    checks++;
    if (status !== 32'h11223344 || status_upd !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle status=%h upd=%b want 11223344 1", status, status_upd);
    end
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] cmd;
    bit c;
    int r, n;
    for (int f = 0; f < 60; f++) begin
      q = {};
      r = $urandom_range(0, 9);
      if (r < 4) cmd = 8'h1E;
      else if (r < 7) cmd = 8'h15;
      else begin
        cmd = 8'($urandom);
        while (cmd == 8'h1E || cmd == 8'h15) cmd = 8'($urandom);
      end
      n = $urandom_range(0, 6);
      if ($urandom_range(0, 7) != 0) begin
        q.push_back(cmd);
        for (int k = 0; k < n; k++) q.push_back(8'($urandom));
      end
      send_frame(q, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b1, c);
      checks++;
      if (status !== shown_status() || status_upd !== c || busy !== 1'b0 || err !== m_err) begin
        errors++;
        $display("FAIL random[%0d] status=%h upd=%b busy=%b err=%b want %h %b 0 %b",
                 f, status, status_upd, busy, err, shown_status(), c, m_err);
      end
      repeat ($urandom_range(0, 2)) tick;
    end
  endtask

`ifdef JTFRAME_STATUS_PULSE_EN
  task automatic test_pulse;
    logic [7:0] q[$];
    bit c;
    do_reset;
    q = {8'h1E, 8'h03, 8'h00, 8'h00, 8'h00};
    send_frame(q, 1'b0, 1'b0, 1'b0, c);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (status !== 32'h3) begin
        errors++;
        $display("FAIL pulse_hold[%0d] got %h want 00000003", k, status);
      end
      tick;
    end
    checks++;
    if (status !== 32'h2) begin errors++; $display("FAIL pulse_clear got %h want 00000002", status); end
  endtask
`endif

  initial begin
    test_reset;
    test_empty_frame;
    test_st32;
    test_st8;
    test_skip_and_oversize;
    test_short;
    test_mid_reset;
    test_abort;
    do_reset;
    test_same_cycle;
    test_random;
`ifdef JTFRAME_STATUS_PULSE_EN
    test_pulse;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
